// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-side register block, TX FIFO and begin/busy sequencer for an 8N1 UART core.
// Optional interrupt output enabled by defining UART_CTRL_IRQ_EN (irq tied low otherwise).
module uart_ctrl #(
  parameter int unsigned TX_DEPTH_LOG2 = 2,
  parameter int unsigned BUSY_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       uart_tx_en,
  output logic       uart_rx_en,
  output logic       uart_begin,
  output logic [7:0] uart_tx_data,
  input  logic       uart_busy,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_done,
  output logic       irq
);

  localparam int unsigned DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned AW    = TX_DEPTH_LOG2;
  localparam int unsigned PTR_W = TX_DEPTH_LOG2 + 1;
  localparam int unsigned TO_W  = 8;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [3:0]       r_ctrl;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [7:0]       r_tx_data;
  logic             r_begin;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic             r_overrun;
  logic             r_rx_done_q;
  logic [7:0]       r_rdata;
  logic [7:0]       w_rd_val;
  logic [7:0]       w_status;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_data_rd;
  logic             w_rx_edge;
  logic             w_tx_active;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_tx_active = (r_state != S_IDLE);
  assign w_pop       = (r_state == S_IDLE) && !w_empty && r_ctrl[0];
  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign w_push      = we && (addr == A_DATA) && (!w_full || w_pop);
  assign w_data_rd   = re && (addr == A_DATA);
  assign w_rx_edge   = uart_rx_done && !r_rx_done_q && r_ctrl[1];
  assign w_status    = {3'b000, w_tx_active, r_overrun, r_rx_valid, w_empty, w_full};

  assign rdata        = r_rdata;
  assign uart_tx_en   = r_ctrl[0];
  assign uart_rx_en   = r_ctrl[1];
  assign uart_begin   = r_begin;
  assign uart_tx_data = r_tx_data;

  // TX sequencer next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_nxt = S_LOAD;
      S_LOAD:      w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (uart_busy)                                  w_state_nxt = S_WAIT_DONE;
        else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1))   w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!uart_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_begin   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= (r_state == S_WAIT_BUSY) ? r_to_cnt + TO_W'(1) : '0;
      r_begin   <= (w_state_nxt == S_START);
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // TX FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // RX holding register; a new byte beats a simultaneous read-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_done_q <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_done_q <= uart_rx_done;
      if (w_rx_edge) begin
        r_rx_byte  <= uart_rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_edge && r_rx_valid && !w_data_rd) r_overrun <= 1'b1;
      else if (we && (addr == A_STATUS) && wdata[3]) r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    case (addr)
      A_DATA:   w_rd_val = r_rx_byte;
      A_STATUS: w_rd_val = w_status;
      A_CTRL:   w_rd_val = {4'b0000, r_ctrl};
      default:  w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= 4'h0;
      r_rdata <= 8'h00;
    end else begin
      if (re) r_rdata <= w_rd_val;
      if (we && (addr == A_CTRL)) r_ctrl <= wdata[3:0];
    end
  end

`ifdef UART_CTRL_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= (r_ctrl[2] & r_rx_valid) | (r_ctrl[3] & w_empty & ~w_tx_active);
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: register vector table, hand-written TX/RX/reset/irq sequences,
// and a randomized register/RX phase checked against a queue-based model.
module tb_uart_ctrl;

  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned TIMEOUT    = 15;
`ifdef UART_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       we;
  logic       re;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       uart_tx_en;
  logic       uart_rx_en;
  logic       uart_begin;
  logic [7:0] uart_tx_data;
  logic       uart_busy;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       irq;

  uart_ctrl #(.TX_DEPTH_LOG2(DEPTH_LOG2), .BUSY_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .uart_tx_en(uart_tx_en), .uart_rx_en(uart_rx_en),
    .uart_begin(uart_begin), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_done(uart_rx_done), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;
  int cyc;
  int busy_mode;   // 0: normal UART, 1: never busy, 2: always busy
  int bcnt;
  logic [7:0] begin_q[$];
  int         begin_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART core stand-in: logs each begin pulse and answers with a busy window
  always @(posedge clk) begin
    if (uart_begin) begin
      begin_q.push_back(uart_tx_data);
      begin_t.push_back(cyc);
      bcnt <= 6;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end
    uart_busy <= (busy_mode == 2) || (busy_mode == 0 && (uart_begin || bcnt > 1));
  end

  typedef struct {
    logic       v_we;
    logic       v_re;
    logic [1:0] v_addr;
    logic [7:0] v_wdata;
    logic [7:0] v_exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] e);
    vec_t v;
    v.v_we = w; v.v_re = r; v.v_addr = a; v.v_wdata = d; v.v_exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    uart_rx_data = d; uart_rx_done = 1'b1;
    tick();
    uart_rx_done = 1'b0;
    tick();
  endtask

  task automatic reset_dut();
    reset = 1'b1; we = 1'b0; re = 1'b0; uart_rx_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_begins(input int n, input int budget, input string name);
    int k = 0;
    while (begin_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(begin_q.size() >= n), 32'(1));
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (i < begin_q.size()) ? begin_q[i] : 8'hxx;
  endfunction

  function automatic int t_at(input int i);
    return (i < begin_t.size()) ? begin_t[i] : -1000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] d;
  logic [7:0] exp_list[4];
  // reference model state for the randomized phase
  logic [3:0] m_ctrl;
  logic [7:0] m_byte;
  logic       m_valid;
  logic       m_ovr;
  logic       m_prev;
  logic [7:0] m_q[$];
  logic [7:0] m_last;

  initial begin
    addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 8'h00;
    uart_rx_data = 8'h00; uart_rx_done = 1'b0; reset = 1'b1;
    busy_mode = 0;

    // register access table: reset values, CTRL storage, reserved address, FIFO fill/drop
    add(0, 1, 2'd1, 8'h00, 8'h02);
    add(0, 1, 2'd2, 8'h00, 8'h00);
    add(0, 1, 2'd0, 8'h00, 8'h00);
    add(1, 0, 2'd2, 8'hFC, 8'h00);
    add(0, 1, 2'd2, 8'h00, 8'h0C);
    add(0, 1, 2'd3, 8'h00, 8'h00);
    add(1, 0, 2'd3, 8'hFF, 8'h00);
    add(0, 1, 2'd2, 8'h00, 8'h0C);
    add(1, 0, 2'd0, 8'h11, 8'h00);
    add(0, 1, 2'd1, 8'h00, 8'h00);
    add(1, 0, 2'd0, 8'h22, 8'h00);
    add(1, 0, 2'd0, 8'h33, 8'h00);
    add(1, 0, 2'd0, 8'h44, 8'h00);
    add(0, 1, 2'd1, 8'h00, 8'h01);
    add(1, 0, 2'd0, 8'h99, 8'h00);
    add(1, 1, 2'd2, 8'h00, 8'h0C);
    add(0, 1, 2'd2, 8'h00, 8'h00);
    add(0, 1, 2'd1, 8'h00, 8'h01);

    reset_dut();
    chk("rst_rdata", 32'(rdata), 32'(8'h00));
    chk("rst_begin", 32'(uart_begin), 32'(0));
    chk("rst_tx_data", 32'(uart_tx_data), 32'(8'h00));
    chk("rst_irq", 32'(irq), 32'(0));
    for (int i = 0; i < vecs.size(); i++) begin
      addr = vecs[i].v_addr; wdata = vecs[i].v_wdata;
      we = vecs[i].v_we; re = vecs[i].v_re;
      tick();
      we = 1'b0; re = 1'b0;
      if (vecs[i].v_re) chk($sformatf("vec[%0d]", i), 32'(rdata), 32'(vecs[i].v_exp));
    end

    // full FIFO drains in order once TX is enabled; dropped 5th byte never appears
    begin_q.delete();
    wr(2'd2, 8'h01);
    chk("tx_en_pin", 32'(uart_tx_en), 32'(1));
    wait_begins(4, 200, "fifo_drain_begins");
    repeat (20) tick();
    chk("fifo_drain_count", 32'(begin_q.size()), 32'(4));
    exp_list = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) chk($sformatf("fifo_order[%0d]", i), 32'(q_at(i)), 32'(exp_list[i]));

    // single byte: one begin, data held, STATUS shows tx_active with empty FIFO
    begin_q.delete();
    wr(2'd0, 8'h55);
    wait_begins(1, 20, "single_begin");
    chk("single_tx_data", 32'(uart_tx_data), 32'(8'h55));
    rd(2'd1, d);
    chk("single_status_active", 32'(d), 32'(8'h12));
    chk("single_tx_data_held", 32'(uart_tx_data), 32'(8'h55));
    repeat (20) tick();
    chk("single_begin_count", 32'(begin_q.size()), 32'(1));
    rd(2'd1, d);
    chk("single_status_idle", 32'(d), 32'(8'h02));

    // busy never rises: begin, TIMEOUT cycles waiting, IDLE, LOAD, next begin
    busy_mode = 1;
    begin_q.delete(); begin_t.delete();
    wr(2'd0, 8'hA5);
    wr(2'd0, 8'h5A);
    wait_begins(2, 80, "timeout_restart");
    chk("timeout_gap", 32'(t_at(1) - t_at(0)), 32'(TIMEOUT + 3));
    chk("timeout_second_data", 32'(q_at(1)), 32'(8'h5A));
    repeat (25) tick();
    rd(2'd1, d);
    chk("timeout_idle_status", 32'(d), 32'(8'h02));
    busy_mode = 0;

    // RX: overrun, read clear, coincident edge/read, rx disabled
    wr(2'd2, 8'h02);
    rx_pulse(8'hA1);
    rx_pulse(8'hB2);
    rd(2'd1, d);
    chk("rx_overrun_status", 32'(d), 32'(8'h0E));
    rd(2'd0, d);
    chk("rx_last_byte", 32'(d), 32'(8'hB2));
    repeat (3) tick();
    chk("rdata_hold", 32'(rdata), 32'(8'hB2));
    rd(2'd1, d);
    chk("rx_valid_cleared", 32'(d), 32'(8'h0A));
    wr(2'd1, 8'h08);
    rd(2'd1, d);
    chk("overrun_cleared", 32'(d), 32'(8'h02));
    uart_rx_data = 8'hC3; uart_rx_done = 1'b1; addr = 2'd0; re = 1'b1;
    tick();
    re = 1'b0; uart_rx_done = 1'b0;
    chk("coincident_read_old", 32'(rdata), 32'(8'hB2));
    tick();
    rd(2'd1, d);
    chk("coincident_no_overrun", 32'(d), 32'(8'h06));
    rd(2'd0, d);
    chk("coincident_byte", 32'(d), 32'(8'hC3));
    wr(2'd2, 8'h00);
    rx_pulse(8'hD4);
    rd(2'd1, d);
    chk("rx_disabled_status", 32'(d), 32'(8'h02));
    rd(2'd0, d);
    chk("rx_disabled_data", 32'(d), 32'(8'hC3));

    // reset while waiting for busy to fall
    busy_mode = 2;
    begin_q.delete();
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h77);
    wr(2'd0, 8'h88);
    wait_begins(1, 20, "wait_done_begin");
    rd(2'd1, d);
    chk("wait_done_status", 32'(d), 32'(8'h10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rdata", 32'(rdata), 32'(8'h00));
    chk("mid_rst_begin", 32'(uart_begin), 32'(0));
    chk("mid_rst_tx_data", 32'(uart_tx_data), 32'(8'h00));
    chk("mid_rst_tx_en", 32'(uart_tx_en), 32'(0));
    chk("mid_rst_rx_en", 32'(uart_rx_en), 32'(0));
    chk("mid_rst_irq", 32'(irq), 32'(0));
    rd(2'd1, d);
    chk("mid_rst_status", 32'(d), 32'(8'h02));
    busy_mode = 0;
    repeat (10) tick();

    // interrupt causes (constant 0 when the feature is compiled out)
    begin_q.delete();
    wr(2'd2, 8'h0B);
    repeat (3) tick();
    chk("irq_txe_idle", 32'(irq), 32'(IRQ_ON));
    wr(2'd0, 8'h3C);
    tick();
    chk("irq_txe_falls", 32'(irq), 32'(0));
    wait_begins(1, 20, "irq_byte_begin");
    repeat (20) tick();
    chk("irq_txe_again", 32'(irq), 32'(IRQ_ON));
    wr(2'd2, 8'h06);
    repeat (2) tick();
    chk("irq_rx_none", 32'(irq), 32'(0));
    rx_pulse(8'hE5);
    tick();
    chk("irq_rx_set", 32'(irq), 32'(IRQ_ON));
    rd(2'd0, d);
    tick();
    chk("irq_rx_clear", 32'(irq), 32'(0));

    // randomized register/RX traffic with TX held off, FIFO checked on final drain
    reset_dut();
    begin_q.delete();
    m_ctrl = 4'h0; m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_prev = 1'b0;
    m_q.delete(); m_last = 8'h00;
    for (int s = 0; s < 400; s++) begin
      logic t_we, t_re, t_done, t_edge, t_dread;
      logic [1:0] t_a;
      logic [7:0] t_d, t_rx, t_exp;
      t_we   = ($urandom_range(0, 3) == 0);
      t_re   = ($urandom_range(0, 2) == 0);
      t_a    = 2'($urandom_range(0, 3));
      t_d    = 8'($urandom);
      t_rx   = 8'($urandom);
      t_done = ($urandom_range(0, 2) == 0);
      if (t_we && t_a == 2'd2) t_d[0] = 1'b0;
      if (t_we && t_a == 2'd1 && t_d[3]) t_done = m_prev;
      case (t_a)
        2'd0:    t_exp = m_byte;
        2'd1:    t_exp = {3'b000, 1'b0, m_ovr, m_valid, m_q.size() == 0, m_q.size() == DEPTH};
        2'd2:    t_exp = {4'h0, m_ctrl};
        default: t_exp = 8'h00;
      endcase
      we = t_we; re = t_re; addr = t_a; wdata = t_d;
      uart_rx_done = t_done; uart_rx_data = t_rx;
      tick();
      we = 1'b0; re = 1'b0;
      if (t_re) begin
        chk($sformatf("rand_read[%0d]", s), 32'(rdata), 32'(t_exp));
        m_last = t_exp;
      end else begin
        chk($sformatf("rand_hold[%0d]", s), 32'(rdata), 32'(m_last));
      end
      t_edge  = t_done && !m_prev && m_ctrl[1];
      t_dread = t_re && (t_a == 2'd0);
      if (t_we) begin
        if (t_a == 2'd0 && m_q.size() < DEPTH) m_q.push_back(t_d);
        if (t_a == 2'd1 && t_d[3]) m_ovr = 1'b0;
        if (t_a == 2'd2) m_ctrl = t_d[3:0];
      end
      if (t_edge) begin
        if (m_valid && !t_dread) m_ovr = 1'b1;
        m_byte = t_rx;
        m_valid = 1'b1;
      end else if (t_dread) begin
        m_valid = 1'b0;
      end
      m_prev = t_done;
    end
    uart_rx_done = 1'b0;
    chk("rand_no_tx", 32'(begin_q.size()), 32'(0));
    wr(2'd2, 8'h01);
    wait_begins(m_q.size(), 400, "rand_drain");
    repeat (30) tick();
    chk("rand_drain_count", 32'(begin_q.size()), 32'(m_q.size()));
    for (int i = 0; i < m_q.size(); i++)
      chk($sformatf("rand_drain[%0d]", i), 32'(q_at(i)), 32'(m_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
